// File: rtl/obi_sram_bridge.sv
// obi_sram_bridge
//   Terminates the interconnect slave req/gnt/rvalid protocol and drives a
//   single-port synchronous SRAM with a fixed read latency of MEM_LATENCY.
//   Accesses are tracked in a MEM_LATENCY-deep pipe of {valid, we} entries.
//   Grant is throttled so no more than MAX_OUTSTANDING accesses are ever in
//   flight. Each retiring access produces one registered rvalid pulse.
//
//   Optional feature macro: OBI_SRAM_BRIDGE_WRITE_RESP_EN
//     defined   : writes also retire with an rvalid pulse and rdata = 0.
//     undefined : only reads pulse rvalid. Writes still hold a tracker slot
//                 until they retire, and they never touch rdata.

module obi_sram_bridge #(
    parameter int DATA_WIDTH       = 32,
    parameter int SLAVE_ADDR_WIDTH = 10,
    parameter int MEM_LATENCY      = 1,
    parameter int MAX_OUTSTANDING  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          slave_data_req_i,
    input  logic [SLAVE_ADDR_WIDTH-1:0]   slave_data_addr_i,
    input  logic                          slave_data_we_i,
    input  logic [DATA_WIDTH/8-1:0]       slave_data_be_i,
    input  logic [DATA_WIDTH-1:0]         slave_data_wdata_i,
    output logic                          slave_data_gnt_o,
    output logic                          slave_data_rvalid_o,
    output logic [DATA_WIDTH-1:0]         slave_data_rdata_o,
    output logic                          mem_en_o,
    output logic                          mem_we_o,
    output logic [DATA_WIDTH/8-1:0]       mem_wmask_o,
    output logic [SLAVE_ADDR_WIDTH-3:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

    localparam int         BE_W    = DATA_WIDTH / 8;
    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    // One tracker entry per pipeline stage of the SRAM read path.
    typedef struct packed {
        logic vld;
        logic we;
    } trk_t;

    trk_t [MEM_LATENCY-1:0] vld_pipe;
    logic [2:0]             count;
    logic                   accept;
    logic                   retire;
    logic                   retire_we;
    logic                   resp_fire;
    logic                   unused_addr;

    // Byte offset within the word carries no meaning for a word-wide SRAM.
    assign unused_addr = ^slave_data_addr_i[1:0];

    assign retire    = vld_pipe[MEM_LATENCY-1].vld;
    assign retire_we = vld_pipe[MEM_LATENCY-1].we;

    // A retiring entry frees its slot in the same cycle, so a full tracker
    // can still accept while something leaves. Reset forces grant low so no
    // SRAM access escapes while state is being cleared.
    assign slave_data_gnt_o = slave_data_req_i & ~reset &
                              ((count - {2'b00, retire}) < MAX_OUT);
    assign accept           = slave_data_req_i & slave_data_gnt_o;

    // SRAM strobes come straight from the accepted request.
    assign mem_en_o    = accept;
    assign mem_we_o    = accept & slave_data_we_i;
    assign mem_wmask_o = (accept & slave_data_we_i) ? slave_data_be_i : {BE_W{1'b0}};
    assign mem_addr_o  = slave_data_addr_i[SLAVE_ADDR_WIDTH-1:2];
    assign mem_wdata_o = slave_data_wdata_i;

`ifdef OBI_SRAM_BRIDGE_WRITE_RESP_EN
    assign resp_fire = retire;
`else
    assign resp_fire = retire & ~retire_we;
`endif

    // Tracker shift register: stage 0 captures this cycle's accept. The last
    // stage lines up with the cycle in which mem_rdata_i is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= '{vld: accept, we: accept & slave_data_we_i};
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    // Outstanding count. An accept and a retire in the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + {2'b00, accept} - {2'b00, retire};
        end
    end

    // Response register. The rvalid pulse lasts exactly one cycle, and rdata
    // keeps its last value between responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slave_data_rvalid_o <= 1'b0;
            slave_data_rdata_o  <= '0;
        end else begin
            slave_data_rvalid_o <= resp_fire;
            if (resp_fire) begin
                slave_data_rdata_o <= retire_we ? {DATA_WIDTH{1'b0}} : mem_rdata_i;
            end
        end
    end

endmodule

// File: doc/obi_sram_bridge.md
# obi_sram_bridge

Slave-side adapter that sits directly downstream of one slave port of the data interconnect. It terminates the slave request/grant/rvalid protocol and drives a single-port synchronous SRAM macro with fixed read latency. It tracks in-flight accesses, throttles grant so the outstanding count never exceeds a configured limit, and returns read data with a single rvalid pulse per response.

## Interface

Parameters:
- DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- SLAVE_ADDR_WIDTH, 10, byte address width from the interconnect.
- MEM_LATENCY, 1, cycles from mem_en_o sample to mem_rdata_i valid; legal range 1..4.
- MAX_OUTSTANDING, 2, maximum accepted-but-unretired accesses; legal range 1..7.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- slave_data_req_i  input  1  request from interconnect.
- slave_data_addr_i  input  SLAVE_ADDR_WIDTH  byte address.
- slave_data_we_i  input  1  1 = write, 0 = read.
- slave_data_be_i  input  DATA_WIDTH/8  byte enables.
- slave_data_wdata_i  input  DATA_WIDTH  write data.
- slave_data_gnt_o  output  1  request accepted this cycle (combinational).
- slave_data_rvalid_o  output  1  response valid (registered).
- slave_data_rdata_o  output  DATA_WIDTH  response data (registered).
- mem_en_o  output  1  SRAM access strobe.
- mem_we_o  output  1  SRAM write enable.
- mem_wmask_o  output  DATA_WIDTH/8  SRAM byte write mask.
- mem_addr_o  output  SLAVE_ADDR_WIDTH-2  SRAM word address.
- mem_wdata_o  output  DATA_WIDTH  SRAM write data.
- mem_rdata_i  input  DATA_WIDTH  SRAM read data.

## Operation

- Accept condition: accept = slave_data_req_i & slave_data_gnt_o.
- slave_data_gnt_o = slave_data_req_i & ((count − retire) < MAX_OUTSTANDING), where retire is 1 when a tracker entry exits this cycle.
- Memory outputs are combinational from the request:
  - mem_en_o = accept.
  - mem_we_o = accept & we.
  - mem_wmask_o = be when accept & we, else 0.
  - mem_addr_o = addr[SLAVE_ADDR_WIDTH-1:2].
  - mem_wdata_o = wdata.
- Address bits [1:0] are ignored; no misalignment error is raised.
- Tracker: a MEM_LATENCY-deep shift register of {valid, we} entries. Stage 0 loads {accept, we} each cycle. retire = valid bit of the last stage.
- Response generation: on retire, slave_data_rvalid_o goes high for exactly 1 cycle (subject to Configuration).
  - Read retire: slave_data_rdata_o <= mem_rdata_i.
  - Write retire: slave_data_rdata_o <= 0.
  - When rvalid is low, rdata holds its last value.
- Outstanding counter: count is 3 bits wide.
  - count <= count + accept − retire.
  - Simultaneous accept and retire leaves count unchanged.
  - count never exceeds MAX_OUTSTANDING and never underflows.
- Full throughput of one access per cycle requires MAX_OUTSTANDING >= MEM_LATENCY. Below that, gnt is deasserted until retire frees a slot.
- Reset (asynchronous, any time): tracker cleared, count = 0, slave_data_rvalid_o = 0, slave_data_rdata_o = 0. In-flight responses are discarded. gnt and mem_* follow the combinational rules above, so mem_en_o = 0 while reset is held because gnt is forced low during reset.

## Timing

- Read accepted in cycle N → rvalid high in cycle N+MEM_LATENCY+1 (latency stage plus output register).
- Write accepted in cycle N → rvalid in cycle N+MEM_LATENCY+1 (see Configuration).
- Responses return strictly in acceptance order; there is no backpressure on rvalid.
- The gnt path is combinational from req and registered state only; there is no path from mem_rdata_i to gnt.
- First edge after reset deassertion: accept is legal.

## Configuration

- Macro: OBI_SRAM_BRIDGE_WRITE_RESP_EN.
- Defined: writes retire with an rvalid pulse and rdata = 0, as above.
- Undefined:
  - Writes produce no rvalid; only reads pulse rvalid.
  - Write tracker entries still occupy a slot and decrement count at retire, so grant throttling is unchanged.
  - slave_data_rdata_o is not updated by write retirement.

## Test plan

- MEM_LATENCY=1, MAX_OUTSTANDING=2; read addr 0x004, mem_rdata_i=0xDEADBEEF → mem_en_o=1 and mem_addr_o=1 in cycle N; rvalid=1 and rdata=0xDEADBEEF in N+2, for one cycle.
- Write addr 0x008, be=4'b0011, wdata=0x12345678 → mem_we_o=1, mem_wmask_o=4'b0011, mem_addr_o=2; with macro, rvalid in N+2 with rdata=0; without macro, no rvalid.
- MEM_LATENCY=2, MAX_OUTSTANDING=2; req held high for 8 cycles of reads → gnt high every cycle; 8 rvalid pulses in order, on consecutive cycles starting at the third cycle after the first accept.
- MEM_LATENCY=3, MAX_OUTSTANDING=1; req held high → gnt pattern 1,0,0,1,0,0,…; count never exceeds 1.
- Assert reset for 1 cycle with 2 reads in flight → no rvalid for the dropped reads; count=0 afterwards; a new read completes with normal latency.
- Accept and retire in the same cycle at count=MAX_OUTSTANDING → gnt=1 and count unchanged.
